// File: rtl/map_access_arbiter.sv
// Map RAM arbiter: shares the single-port wall map between the VGA renderer
// (never stalls), the game logic (req/gnt handshake) and a full-map clear.
module map_access_arbiter #(
    parameter int unsigned MAP_W  = 64,
    parameter int unsigned MAP_H  = 44,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        vga_req_x,
    input  logic [5:0]        vga_req_y,
    output logic              vga_is_wall,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [5:0]        game_x,
    input  logic [5:0]        game_y,
    input  logic              game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic              game_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    localparam int unsigned CLR_LAST = MAP_H * MAP_W - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic                w_clr_write;
    logic                w_clear_done_nxt;
    logic                r_clear_busy;
    logic                r_clear_done;

    logic [ADDR_W-1:0]   w_vga_addr;
    logic [ADDR_W-1:0]   r_vga_addr;
    logic                r_vga_valid;
    logic                r_vga_pend;
    logic                r_vga_is_wall;
    logic                w_vga_access;

    logic [ADDR_W-1:0]   w_game_addr;
    logic                w_game_oob;
    logic                w_game_grant;
    logic                r_game_rvalid;
    logic                r_game_oob;

    assign w_vga_addr   = ADDR_W'({vga_req_y, vga_req_x});
    assign w_game_addr  = ADDR_W'({game_y, game_x});
    assign w_vga_access = !r_vga_valid || (w_vga_addr != r_vga_addr);
    assign w_game_oob   = (32'(game_y) >= MAP_H);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, clear sequencing and game grant; VGA slots pre-empt both
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_clr_write      = 1'b0;
        w_clear_done_nxt = 1'b0;
        w_game_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end else if (game_req && !w_vga_access) begin
                    w_game_grant = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (!w_vga_access) begin
                    w_clr_write = 1'b1;
                    if (r_clr_cnt == ADDR_W'(CLR_LAST)) begin
                        w_state_nxt      = ST_IDLE;
                        w_clear_done_nxt = 1'b1;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM port mux: VGA first, then granted in-range game access, then clear write
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        if (w_vga_access) begin
            mem_en   = 1'b1;
            mem_addr = w_vga_addr;
        end else if (w_game_grant && !w_game_oob) begin
            mem_en    = 1'b1;
            mem_we    = game_we;
            mem_addr  = w_game_addr;
            mem_wdata = game_wdata;
        end else if (w_clr_write) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_clr_cnt;
            mem_wdata = 1'b0;
        end
    end

    // Clear counter and clear status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt    <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_clear_busy <= (w_state_nxt == ST_CLEAR);
            r_clear_done <= w_clear_done_nxt;
        end
    end

    // Last VGA address tracking and wall capture one cycle after the fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_addr    <= '0;
            r_vga_valid   <= 1'b0;
            r_vga_pend    <= 1'b0;
            r_vga_is_wall <= 1'b0;
        end else begin
            r_vga_pend <= w_vga_access;
            if (w_vga_access) begin
                r_vga_addr  <= w_vga_addr;
                r_vga_valid <= 1'b1;
            end
            if (r_vga_pend) begin
                r_vga_is_wall <= mem_rdata;
            end
        end
    end

    // Game read return tracking; out-of-map reads report a wall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_game_rvalid <= 1'b0;
            r_game_oob    <= 1'b0;
        end else begin
            r_game_rvalid <= w_game_grant && !game_we;
            r_game_oob    <= w_game_oob;
        end
    end

    assign vga_is_wall = r_vga_is_wall;
    assign game_gnt    = w_game_grant;
    assign game_rvalid = r_game_rvalid;
    assign game_rdata  = r_game_rvalid && (r_game_oob || mem_rdata);
    assign clear_busy  = r_clear_busy;
    assign clear_done  = r_clear_done;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter with a behavioural 1-cycle map RAM
// and a queue of expected game read data.
module tb_map_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  vga_req_x;
    logic [5:0]  vga_req_y;
    logic        vga_is_wall;
    logic        game_req;
    logic        game_we;
    logic [5:0]  game_x;
    logic [5:0]  game_y;
    logic        game_wdata;
    logic        game_gnt;
    logic        game_rvalid;
    logic        game_rdata;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic        mem_wdata;
    logic        mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    logic ram [0:4095];
    logic exp_q [$];
    logic exp_pop;

    map_access_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_req_x   (vga_req_x),
        .vga_req_y   (vga_req_y),
        .vga_is_wall (vga_is_wall),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_x      (game_x),
        .game_y      (game_y),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, read-first, registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every game read return is compared with the queued expectation
    always @(negedge clk) begin
        if (rst_n && game_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_pop = exp_q.pop_front();
                chk("game_rdata", game_rdata, exp_pop);
            end
        end
    end

    // Change the VGA cell and follow the fetch through to vga_is_wall
    task automatic vga_fetch(input logic [5:0] x, input logic [5:0] y,
                             input logic prev_wall, input logic exp_wall, input string tag);
        vga_req_x = x;
        vga_req_y = y;
        #1;
        chk({tag, "_en"}, mem_en, 1'b1);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, {y, x});
        tick();
        chk({tag, "_hold"}, vga_is_wall, prev_wall);
        tick();
        chk({tag, "_wall"}, vga_is_wall, exp_wall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int slots;
        int writes;
        int bad;
        int gnt_seen;
        int busy_bad;
        int done_k;
        int done_seen;
        logic [11:0] exp_addr;

        for (int i = 0; i < 4096; i++) ram[i] = 1'b0;
        ram[0]       = 1'b1;
        ram[12'h14A] = 1'b1;
        mem_rdata    = 1'b0;

        rst_n       = 1'b0;
        vga_req_x   = '0;
        vga_req_y   = '0;
        game_req    = 1'b0;
        game_we     = 1'b0;
        game_x      = '0;
        game_y      = '0;
        game_wdata  = 1'b0;
        clear_start = 1'b0;

        repeat (3) tick();
        chk("rst_vga_is_wall", vga_is_wall, 1'b0);
        chk("rst_game_gnt",    game_gnt,    1'b0);
        chk("rst_game_rvalid", game_rvalid, 1'b0);
        chk("rst_game_rdata",  game_rdata,  1'b0);
        chk("rst_clear_busy",  clear_busy,  1'b0);
        chk("rst_clear_done",  clear_done,  1'b0);

        // Cycle 1 after release: fetch of (0,0) because nothing is cached yet
        rst_n = 1'b1;
        #1;
        chk("c1_mem_en",   mem_en,   1'b1);
        chk("c1_mem_addr", mem_addr, 12'h000);
        tick();
        #1;
        chk("c2_vga_is_wall", vga_is_wall, 1'b0);
        chk("c2_mem_en_idle", mem_en,      1'b0);
        tick();
        chk("c3_vga_is_wall", vga_is_wall, 1'b1);

        vga_fetch(6'd1,  6'd0, 1'b1, 1'b0, "vga_1_0");
        vga_fetch(6'd10, 6'd5, 1'b0, 1'b1, "vga_10_5");

        // Game write (3,2)=1 with the VGA address steady
        game_req = 1'b1; game_we = 1'b1; game_x = 6'd3; game_y = 6'd2; game_wdata = 1'b1;
        #1;
        chk("wr_gnt",   game_gnt,  1'b1);
        chk("wr_en",    mem_en,    1'b1);
        chk("wr_we",    mem_we,    1'b1);
        chk("wr_addr",  mem_addr,  12'h083);
        chk("wr_wdata", mem_wdata, 1'b1);
        tick();
        game_req = 1'b0; game_we = 1'b0; game_wdata = 1'b0;
        #1;
        chk("wr_no_rvalid", game_rvalid, 1'b0);
        tick();

        // Back-to-back reads: (4,2)=0 then (3,2)=1
        game_req = 1'b1; game_x = 6'd4; game_y = 6'd2;
        #1;
        chk("rd0_gnt", game_gnt, 1'b1);
        exp_q.push_back(1'b0);
        tick();
        game_x = 6'd3;
        #1;
        chk("rd1_gnt",    game_gnt,    1'b1);
        chk("rd1_rvalid", game_rvalid, 1'b1);
        exp_q.push_back(1'b1);
        tick();
        game_req = 1'b0;
        #1;
        chk("rd1_rvalid_next", game_rvalid, 1'b1);
        chk("rd1_gnt_low",     game_gnt,    1'b0);
        tick();
        #1;
        chk("rd_rvalid_pulse", game_rvalid, 1'b0);

        // Game read colliding with a VGA change: VGA (20,7)=0 first, game (3,2)=1 next
        vga_req_x = 6'd20; vga_req_y = 6'd7;
        game_req = 1'b1; game_x = 6'd3; game_y = 6'd2;
        #1;
        chk("col_gnt_blocked", game_gnt, 1'b0);
        chk("col_vga_addr",    mem_addr, 12'h1D4);
        chk("col_vga_we",      mem_we,   1'b0);
        tick();
        #1;
        chk("col_gnt_late",  game_gnt, 1'b1);
        chk("col_game_addr", mem_addr, 12'h083);
        exp_q.push_back(1'b1);
        tick();
        game_req = 1'b0;
        #1;
        chk("col_rvalid",      game_rvalid, 1'b1);
        chk("col_vga_is_wall", vga_is_wall, 1'b0);
        tick();
        chk("col_vga_hold",    vga_is_wall, 1'b0);

        // Out-of-map read after a zero read: must report wall without touching RAM
        game_req = 1'b1; game_x = 6'd4; game_y = 6'd2;
        #1;
        exp_q.push_back(1'b0);
        tick();
        game_x = 6'd1; game_y = 6'd50;
        #1;
        chk("oob_rd_gnt", game_gnt, 1'b1);
        chk("oob_rd_en",  mem_en,   1'b0);
        exp_q.push_back(1'b1);
        tick();
        game_we = 1'b1; game_wdata = 1'b1; game_y = 6'd63;
        #1;
        chk("oob_rvalid", game_rvalid, 1'b1);
        chk("oob_wr_gnt", game_gnt,    1'b1);
        chk("oob_wr_en",  mem_en,      1'b0);
        tick();
        game_req = 1'b0; game_we = 1'b0; game_wdata = 1'b0;
        tick();

        // Clear with a concurrent game read; VGA moves every 10 cycles
        clear_start = 1'b1;
        game_req = 1'b1; game_we = 1'b0; game_x = 6'd3; game_y = 6'd2;
        #1;
        chk("clr_start_no_gnt", game_gnt, 1'b0);
        chk("clr_start_no_en",  mem_en,   1'b0);
        tick();
        clear_start = 1'b0;
        slots = 0; writes = 0; bad = 0; gnt_seen = 0; busy_bad = 0; done_k = 0;
        exp_addr = '0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 10 == 0) begin
                vga_req_x = 6'(k / 10);
                vga_req_y = 6'd9;
                slots++;
            end
            clear_start = (k == 500);
            #1;
            if (game_gnt) gnt_seen++;
            if (clear_busy !== 1'b1) busy_bad++;
            if (mem_en && mem_we) begin
                if (mem_addr !== exp_addr || mem_wdata !== 1'b0) bad++;
                exp_addr = exp_addr + 12'd1;
                writes++;
            end
            tick();
            clear_start = 1'b0;
            if (clear_done === 1'b1) begin
                done_k = k + 1;
                break;
            end
        end
        chk("clr_writes",      writes,   2816);
        chk("clr_addr_errors", bad,      0);
        chk("clr_gnt_seen",    gnt_seen, 0);
        chk("clr_busy_gaps",   busy_bad, 0);
        chk("clr_done_cycle",  done_k,   2816 + slots);
        chk("clr_done_pulse",  clear_done, 1'b1);
        chk("clr_busy_low",    clear_busy, 1'b0);
        #1;
        chk("post_clr_gnt", game_gnt, 1'b1);
        exp_q.push_back(1'b0);
        tick();
        game_req = 1'b0;
        #1;
        chk("post_clr_rvalid", game_rvalid, 1'b1);
        chk("clr_done_once",   clear_done,  1'b0);
        tick();

        // Reset in the middle of a clear aborts it silently
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (100) tick();
        chk("mid_clr_busy", clear_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", clear_busy, 1'b0);
        chk("abort_done", clear_done, 1'b0);
        tick();
        rst_n = 1'b1;
        done_seen = 0; busy_bad = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (clear_done !== 1'b0) done_seen++;
            if (clear_busy !== 1'b0) busy_bad++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_no_busy", busy_bad,  0);

        repeat (3) tick();
        chk("rd_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Shares the single-port game map RAM (1 bit per grid cell, 1 = wall) between two requesters:
  - the VGA renderer, which issues one cell address per grid cell and must never stall;
  - the game logic, which reads and writes through a req/gnt handshake.
- Also sequences a full-map clear on request.
- Sits between the VGA block, the game FSM and the map RAM. It drives the VGA wall input from RAM read data.

Parameters:
- MAP_W, 64, grid columns. Fixed at 64, so the address is {y,x}.
- MAP_H, 44, game rows (display rows minus the status bar).
- ADDR_W, 12, RAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vga_req_x  in  6  cell column requested by the VGA (registered in the VGA block)
- vga_req_y  in  6  cell row requested by the VGA
- vga_is_wall  out  1  wall bit for the last VGA request
- game_req  in  1  game access request, held until granted
- game_we  in  1  1 = write, 0 = read
- game_x  in  6  game cell column
- game_y  in  6  game cell row
- game_wdata  in  1  write data
- game_gnt  out  1  one-cycle pulse: access issued this cycle
- game_rvalid  out  1  one-cycle pulse one cycle after a read grant
- game_rdata  out  1  read data, valid with game_rvalid
- clear_start  in  1  pulse: clear the whole map to 0
- clear_busy  out  1  high while the clear sequence runs
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_en  out  1  RAM enable (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_addr  out  12  RAM address = {y,x} (combinational)
- mem_wdata  out  1  RAM write data (combinational)
- mem_rdata  in  1  RAM read data, registered in the RAM, 1-cycle latency

Behaviour:
- Reset:
  - all registered outputs are 0 (vga_is_wall, game_gnt, game_rvalid, game_rdata, clear_busy, clear_done);
  - state = IDLE;
  - last-VGA-address register = 0 with its valid flag = 0.
- VGA slot:
  - a VGA access is needed in a cycle when {vga_req_y,vga_req_x} differs from the last-VGA-address register, or when the valid flag is 0.
  - VGA always wins that cycle: mem_en=1, mem_we=0, mem_addr = VGA address. The register is updated and valid is set to 1.
  - vga_is_wall captures mem_rdata on the following cycle's edge. It is valid exactly 2 cycles after the request change and holds until the next VGA access.
  - No range check on VGA addresses.
- States: IDLE, CLEAR.
- IDLE:
  - if clear_start=1, go to CLEAR at the next edge, with the clear counter = 0 and clear_busy=1. clear_start has priority over game_req in the same cycle; the game request is not granted.
  - else, if game_req=1 and there is no VGA access this cycle, grant: game_gnt=1 and mem_en=1.
    - Write: mem_we=game_we, addr={game_y,game_x}, mem_wdata=game_wdata.
    - Read: game_rvalid=1 on the next cycle with game_rdata=mem_rdata.
  - If game_y >= MAP_H, the request is still granted but touches no RAM (mem_en=0). A read then returns game_rdata=1 (treated as wall).
  - A VGA collision delays the grant by exactly 1 cycle. Because the VGA changes address at most once per 10 cycles, the game gets at least 9 of every 10 slots.
- CLEAR:
  - in each cycle without a VGA access, write 0 to the counter address (mem_we=1) and increment the counter; the counter maps to {y,x}.
  - The counter stops at MAP_H*MAP_W-1 = 2815. On that write, clear_done pulses on the next cycle, clear_busy drops, and the state returns to IDLE.
  - game_req is never granted while in CLEAR.
  - clear_start is ignored while already in CLEAR.
- Reset mid-clear: abort immediately, no clear_done pulse, state = IDLE.
- game_gnt and game_rvalid may both be high in the same cycle (back-to-back reads).

Test Plan:
- Reset release with VGA address (0,0) -> fetch issued in cycle 1 because valid=0; vga_is_wall = RAM[0] at cycle 3.
- Preload RAM[{5,10}]=1; VGA request changes to x=10,y=5 -> mem_addr=0x14A in the same cycle; vga_is_wall=1 two cycles later.
- Game write (x=3,y=2,wdata=1) on a cycle with no VGA change -> game_gnt in the same cycle; mem_addr=0x083, mem_we=1; a subsequent read returns game_rdata=1 with game_rvalid.
- Game read colliding with a VGA address change -> VGA served first; game_gnt exactly 1 cycle later; the VGA result is unaffected.
- Game read with y=50 -> granted with mem_en=0; game_rdata=1.
- clear_start together with game_req; the VGA changes every 10 cycles -> 2816 zero writes; clear_done after 2816 + number-of-VGA-slot cycles; no game_gnt until clear_busy=0; a reset asserted mid-clear gives no clear_done.
